// File: rtl/oled_pkg.sv
// oled_pkg: constants shared by the OLED init sequencer and its neighbours.
//   state_t / ST_*      : sequencer state encoding
//   SSD1306_ADDR        : default 7-bit slave address
//   CTRL_CMD_STREAM     : control byte announcing a command stream
//   CTRL_DATA_STREAM    : control byte announcing a GDDRAM data stream
package oled_pkg;

   localparam logic [6:0] SSD1306_ADDR     = 7'h3C;
   localparam logic [7:0] CTRL_CMD_STREAM  = 8'h00;
   localparam logic [7:0] CTRL_DATA_STREAM = 8'h40;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_ADDR   = 4'd1;
   localparam state_t ST_ADDR_W = 4'd2;
   localparam state_t ST_CTRL   = 4'd3;
   localparam state_t ST_CTRL_W = 4'd4;
   localparam state_t ST_CMD    = 4'd5;
   localparam state_t ST_CMD_W  = 4'd6;
   localparam state_t ST_FIN    = 4'd7;
   localparam state_t ST_FAIL   = 4'd8;

   // I2C address byte for a write transfer (R/W# = 0).
   function automatic logic [7:0] addr_wr_byte(input logic [6:0] addr);
      return {addr, 1'b0};
   endfunction

endpackage

// File: rtl/oled_init_seq.sv
// oled_init_seq: walks the OLED command ROM and frames it as one I2C write
// (address byte, control byte, CMD_COUNT command bytes) towards a byte-level
// I2C master.
//   ck, reset            : clock, asynchronous active-high reset
//   go                   : start request, honoured only when idle
//   rom_addr / rom_data  : command ROM address out, combinational data in
//   tx_valid/ready/data  : byte handshake to the master
//   tx_start / tx_stop   : START before / STOP after the offered byte
//   tx_done / tx_nack    : per-byte completion pulse and its NACK status
//   busy, done, err      : activity flag, success pulse, abort pulse
// Optional: define OLED_SEQ_RETRY_EN to restart the transfer on NACK, up to
// RETRY_MAX times, before reporting err.
module oled_init_seq
   import oled_pkg::*;
#(
   parameter int unsigned CMD_COUNT = 41,
   parameter logic [6:0]  DEV_ADDR  = SSD1306_ADDR,
   parameter logic [7:0]  CTRL_BYTE = CTRL_CMD_STREAM,
   parameter int unsigned RETRY_MAX = 3
) (
   input  logic       ck,
   input  logic       reset,
   input  logic       go,
   output logic [6:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       tx_stop,
   input  logic       tx_done,
   input  logic       tx_nack,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [6:0] LAST_IDX = 7'(CMD_COUNT - 1);

   if (CMD_COUNT < 1 || CMD_COUNT > 128) begin : g_bad_count
      $error("oled_init_seq: CMD_COUNT must be 1..128");
   end
   if (RETRY_MAX > 3) begin : g_bad_retry
      $error("oled_init_seq: RETRY_MAX must fit the 2-bit retry counter");
   end

   state_t     state;
   logic [6:0] idx;
   logic       in_wait;

`ifdef OLED_SEQ_RETRY_EN
   localparam logic [1:0] RETRY_LIM = 2'(RETRY_MAX);
   logic [1:0] retry;
`endif

   // rom_addr follows idx directly; idx only moves in the wait states, so
   // the ROM output has a full cycle to settle before CMD loads tx_data.
   assign rom_addr = idx;

   always_comb begin
      in_wait = (state == ST_ADDR_W) || (state == ST_CTRL_W) || (state == ST_CMD_W);
   end

   // Each send state spends one cycle with tx_valid low (loading tx_data),
   // then offers the byte until tx_ready; this gives the 3-cycle byte rate.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         idx      <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         tx_stop  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef OLED_SEQ_RETRY_EN
         retry    <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (in_wait && tx_done && tx_nack) begin
`ifdef OLED_SEQ_RETRY_EN
            if (retry == RETRY_LIM) begin
               state <= ST_FAIL;
               err   <= 1'b1;
               busy  <= 1'b0;
            end else begin
               retry <= retry + 2'd1;
               idx   <= '0;
               state <= ST_ADDR;
            end
`else
            state <= ST_FAIL;
            err   <= 1'b1;
            busy  <= 1'b0;
`endif
         end else begin
            case (state)
               ST_IDLE: begin
                  if (go) begin
                     state <= ST_ADDR;
                     busy  <= 1'b1;
                     idx   <= '0;
`ifdef OLED_SEQ_RETRY_EN
                     retry <= '0;
`endif
                  end
               end
               ST_ADDR: begin
                  if (!tx_valid) begin
                     tx_valid <= 1'b1;
                     tx_data  <= addr_wr_byte(DEV_ADDR);
                     tx_start <= 1'b1;
                     tx_stop  <= 1'b0;
                  end else if (tx_ready) begin
                     tx_valid <= 1'b0;
                     tx_start <= 1'b0;
                     state    <= ST_ADDR_W;
                  end
               end
               ST_ADDR_W: begin
                  if (tx_done) state <= ST_CTRL;
               end
               ST_CTRL: begin
                  if (!tx_valid) begin
                     tx_valid <= 1'b1;
                     tx_data  <= CTRL_BYTE;
                     tx_start <= 1'b0;
                     tx_stop  <= 1'b0;
                  end else if (tx_ready) begin
                     tx_valid <= 1'b0;
                     state    <= ST_CTRL_W;
                  end
               end
               ST_CTRL_W: begin
                  if (tx_done) begin
                     idx   <= '0;
                     state <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (!tx_valid) begin
                     tx_valid <= 1'b1;
                     tx_data  <= rom_data;
                     tx_start <= 1'b0;
                     tx_stop  <= (idx == LAST_IDX);
                  end else if (tx_ready) begin
                     tx_valid <= 1'b0;
                     tx_stop  <= 1'b0;
                     state    <= ST_CMD_W;
                  end
               end
               ST_CMD_W: begin
                  if (tx_done) begin
                     if (idx == LAST_IDX) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        idx   <= idx + 7'd1;
                        state <= ST_CMD;
                     end
                  end
               end
               ST_FIN:  state <= ST_IDLE;
               ST_FAIL: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oled_init_seq.sv
// tb_oled_init_seq: directed bench for oled_init_seq. A behavioural I2C
// master logs every accepted byte and answers with tx_done one cycle later;
// a second instance covers CMD_COUNT=1. Honours OLED_SEQ_RETRY_EN.
module tb_oled_init_seq;

   localparam int N = 41;
   localparam logic [7:0] ROM_TBL [0:40] = '{
      8'hAE, 8'h20, 8'h01, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hD5,
      8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'hA1, 8'hC8,
      8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
      8'h2E, 8'hAF, 8'hB0, 8'h10, 8'h02, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3,
      8'h00};

   function automatic logic [7:0] rom_byte(input logic [6:0] a);
      if (int'(a) < N) return ROM_TBL[a];
      return 8'h00;
   endfunction

   // Expected {data, start, stop} of the i-th accepted byte for count n.
   function automatic logic [9:0] exp_byte(input int i, input int n);
      if (i == 0) return {8'h78, 1'b1, 1'b0};
      if (i == 1) return {8'h00, 1'b0, 1'b0};
      return {rom_byte(7'(i - 2)), 1'b0, (i == n + 1)};
   endfunction

   logic ck = 1'b0, reset = 1'b0, go = 1'b0;
   logic [6:0] rom_addr;
   logic [7:0] rom_data, tx_data;
   logic tx_valid, tx_ready, tx_start, tx_stop, tx_done, tx_nack, busy, done, err;

   logic go1 = 1'b0;
   logic [6:0] rom_addr1;
   logic [7:0] rom_data1, tx_data1;
   logic tx_valid1, tx_ready1, tx_start1, tx_stop1, tx_done1, tx_nack1, busy1, done1, err1;

   int total = 0, bad = 0;
   logic [9:0] log_q[$];
   logic [9:0] log1_q[$];
   int done_cnt = 0, err_cnt = 0, done1_cnt = 0;
   int nack_at = -1, stall_cnt = 0;

   always #5 ck = ~ck;

   assign rom_data  = rom_byte(rom_addr);
   assign rom_data1 = rom_byte(rom_addr1);

   oled_init_seq #(.CMD_COUNT(41)) u_dut (
      .ck(ck), .reset(reset), .go(go), .rom_addr(rom_addr), .rom_data(rom_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_stop(tx_stop), .tx_done(tx_done), .tx_nack(tx_nack),
      .busy(busy), .done(done), .err(err));

   oled_init_seq #(.CMD_COUNT(1)) u_one (
      .ck(ck), .reset(reset), .go(go1), .rom_addr(rom_addr1), .rom_data(rom_data1),
      .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
      .tx_start(tx_start1), .tx_stop(tx_stop1), .tx_done(tx_done1), .tx_nack(tx_nack1),
      .busy(busy1), .done(done1), .err(err1));

   // Master model for u_dut: decides tx_ready and spots handshakes on the
   // falling edge, answers tx_done during the following cycle.
   initial begin
      bit pend, pend_nack;
      pend = 0; pend_nack = 0;
      tx_ready = 1'b1; tx_done = 1'b0; tx_nack = 1'b0;
      forever begin
         @(negedge ck);
         tx_done = 1'b0; tx_nack = 1'b0;
         if (reset) begin
            pend = 0;
         end else begin
            if (pend) begin tx_done = 1'b1; tx_nack = pend_nack; pend = 0; end
            if (stall_cnt > 0) begin tx_ready = 1'b0; stall_cnt--; end
            else tx_ready = 1'b1;
            if (tx_valid && tx_ready) begin
               log_q.push_back({tx_data, tx_start, tx_stop});
               pend = 1;
               pend_nack = (nack_at == log_q.size() - 1);
               if (pend_nack) nack_at = -1;
            end
            if (done) done_cnt++;
            if (err)  err_cnt++;
         end
      end
   end

   // Master model for u_one: always ready, always ACK.
   initial begin
      bit pend;
      pend = 0;
      tx_ready1 = 1'b1; tx_done1 = 1'b0; tx_nack1 = 1'b0;
      forever begin
         @(negedge ck);
         tx_done1 = 1'b0;
         if (reset) pend = 0;
         else begin
            if (pend) begin tx_done1 = 1'b1; pend = 0; end
            if (tx_valid1 && tx_ready1) begin
               log1_q.push_back({tx_data1, tx_start1, tx_stop1});
               pend = 1;
            end
            if (done1) done1_cnt++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      log_q.delete(); log1_q.delete();
      done_cnt = 0; err_cnt = 0; done1_cnt = 0; nack_at = -1; stall_cnt = 0;
   endtask

   task automatic pulse_go();
      @(posedge ck); #1 go = 1'b1;
      @(posedge ck); #1 go = 1'b0;
   endtask

   task automatic wait_end(output bit timed_out);
      timed_out = 1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge ck); #1;
         if (done_cnt + err_cnt != 0) begin timed_out = 0; break; end
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      total++;
      if ({tx_valid, tx_start, tx_stop, busy, done, err} !== 6'b0 || tx_data !== 8'h00 || rom_addr !== 7'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b/%h/%h want=000000/00/00",
                  {tx_valid, tx_start, tx_stop, busy, done, err}, tx_data, rom_addr);
      end
      repeat (3) @(posedge ck);
      #1 reset = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      total++;
      if ({tx_valid, busy, done, err} !== 4'b0) begin
         bad++; $display("FAIL reset_idle got=%b want=0000", {tx_valid, busy, done, err});
      end
   endtask

   task automatic test_full();
      bit to;
      clear_log();
      pulse_go();
      wait_end(to);
      total++;
      if (to) begin bad++; $display("FAIL full_timeout got=no_end want=done"); end
      repeat (3) @(posedge ck);
      #1;
      total++;
      if (log_q.size() !== N + 2) begin
         bad++; $display("FAIL full_count got=%0d want=%0d", log_q.size(), N + 2);
      end
      for (int i = 0; i < log_q.size() && i < N + 2; i++) begin
         total++;
         if (log_q[i] !== exp_byte(i, N)) begin
            bad++; $display("FAIL full_byte[%0d] got=%h want=%h", i, log_q[i], exp_byte(i, N));
         end
      end
      total++;
      if (done_cnt !== 1 || err_cnt !== 0 || busy !== 1'b0) begin
         bad++; $display("FAIL full_status got=done%0d/err%0d/busy%b want=1/0/0", done_cnt, err_cnt, busy);
      end
   endtask

   task automatic test_nack_addr();
      bit to;
      clear_log();
      nack_at = 0;
      pulse_go();
      wait_end(to);
      repeat (10) @(posedge ck);
      #1;
      total++;
      if (to) begin bad++; $display("FAIL nack_timeout got=no_end want=end"); end
`ifdef OLED_SEQ_RETRY_EN
      total++;
      if (log_q.size() !== N + 3) begin
         bad++; $display("FAIL retry_count got=%0d want=%0d", log_q.size(), N + 3);
      end
      for (int i = 1; i < log_q.size() && i < N + 3; i++) begin
         total++;
         if (log_q[i] !== exp_byte(i - 1, N)) begin
            bad++; $display("FAIL retry_byte[%0d] got=%h want=%h", i, log_q[i], exp_byte(i - 1, N));
         end
      end
      total++;
      if (done_cnt !== 1 || err_cnt !== 0 || busy !== 1'b0) begin
         bad++; $display("FAIL retry_status got=done%0d/err%0d/busy%b want=1/0/0", done_cnt, err_cnt, busy);
      end
`else
      total++;
      if (log_q.size() !== 1) begin
         bad++; $display("FAIL nack_count got=%0d want=1", log_q.size());
      end
      total++;
      if (err_cnt !== 1 || done_cnt !== 0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
         bad++; $display("FAIL nack_status got=err%0d/done%0d/busy%b/valid%b want=1/0/0/0",
                         err_cnt, done_cnt, busy, tx_valid);
      end
`endif
   endtask

   task automatic test_backpressure();
      bit to, seen;
      clear_log();
      seen = 0;
      pulse_go();
      for (int i = 0; i < 1000; i++) begin
         @(posedge ck); #1;
         if (tx_valid && rom_addr == 7'd10) begin seen = 1; break; end
      end
      stall_cnt = 5;
      total++;
      if (!seen) begin bad++; $display("FAIL bp_reach got=not_seen want=idx10_valid"); end
      for (int c = 0; c < 6; c++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== rom_byte(7'd10) || rom_addr !== 7'd10) begin
            bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/%h/10",
                            c, tx_valid, tx_data, rom_addr, rom_byte(7'd10));
         end
         if (c < 5) begin @(posedge ck); #1; end
      end
      wait_end(to);
      repeat (3) @(posedge ck);
      #1;
      total++;
      if (to || log_q.size() !== N + 2) begin
         bad++; $display("FAIL bp_count got=%0d want=%0d", log_q.size(), N + 2);
      end
      for (int i = 0; i < log_q.size() && i < N + 2; i++) begin
         total++;
         if (log_q[i] !== exp_byte(i, N)) begin
            bad++; $display("FAIL bp_byte[%0d] got=%h want=%h", i, log_q[i], exp_byte(i, N));
         end
      end
   endtask

   task automatic test_go_busy();
      bit to;
      clear_log();
      pulse_go();
      for (int i = 0; i < 1000; i++) begin
         @(posedge ck); #1;
         if (busy && rom_addr == 7'd20) break;
      end
      go = 1'b1;
      @(posedge ck); #1 go = 1'b0;
      wait_end(to);
      repeat (5) @(posedge ck);
      #1;
      total++;
      if (to || log_q.size() !== N + 2) begin
         bad++; $display("FAIL gobusy_count got=%0d want=%0d", log_q.size(), N + 2);
      end
      total++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         bad++; $display("FAIL gobusy_status got=done%0d/busy%b want=1/0", done_cnt, busy);
      end
   endtask

   task automatic test_reset_midway();
      bit to, seen;
      clear_log();
      seen = 0;
      pulse_go();
      for (int i = 0; i < 1000; i++) begin
         @(posedge ck); #1;
         if (log_q.size() == 8 && !tx_valid) begin seen = 1; break; end
      end
      total++;
      if (!seen || rom_addr !== 7'd5) begin
         bad++; $display("FAIL mid_reach got=%0d want=5", rom_addr);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({tx_valid, tx_start, tx_stop, busy, done, err} !== 6'b0 || tx_data !== 8'h00 || rom_addr !== 7'd0) begin
         bad++;
         $display("FAIL mid_reset got=%b/%h/%h want=000000/00/00",
                  {tx_valid, tx_start, tx_stop, busy, done, err}, tx_data, rom_addr);
      end
      repeat (2) @(posedge ck);
      #1 reset = 1'b0;
      clear_log();
      pulse_go();
      wait_end(to);
      repeat (3) @(posedge ck);
      #1;
      total++;
      if (log_q.size() == 0 || log_q[0] !== {8'h78, 1'b1, 1'b0}) begin
         bad++; $display("FAIL mid_restart got=%h want=%h", (log_q.size() != 0) ? log_q[0] : 10'h0, {8'h78, 2'b10});
      end
      total++;
      if (to || log_q.size() !== N + 2 || done_cnt !== 1) begin
         bad++; $display("FAIL mid_complete got=%0d/done%0d want=%0d/1", log_q.size(), done_cnt, N + 2);
      end
   endtask

   task automatic test_count_one();
      clear_log();
      @(posedge ck); #1 go1 = 1'b1;
      @(posedge ck); #1 go1 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge ck); #1;
         if (done1_cnt != 0) break;
      end
      repeat (3) @(posedge ck);
      #1;
      total++;
      if (log1_q.size() !== 3) begin
         bad++; $display("FAIL one_count got=%0d want=3", log1_q.size());
      end
      for (int i = 0; i < log1_q.size() && i < 3; i++) begin
         total++;
         if (log1_q[i] !== exp_byte(i, 1)) begin
            bad++; $display("FAIL one_byte[%0d] got=%h want=%h", i, log1_q[i], exp_byte(i, 1));
         end
      end
      total++;
      if (done1_cnt !== 1 || busy1 !== 1'b0) begin
         bad++; $display("FAIL one_status got=done%0d/busy%b want=1/0", done1_cnt, busy1);
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_nack_addr();
      test_backpressure();
      test_go_busy();
      test_reset_midway();
      test_count_one();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oled_init_seq.md
Name: oled_init_seq

Overview:
- Downstream consumer of the OLED command ROM.
- Walks ROM addresses 0..CMD_COUNT-1 and frames the bytes as one I2C write transaction to the SSD1306: address byte, control byte, then every command byte.
- Feeds a byte-level I2C master through a valid/ready handshake and waits for that master's per-byte completion and ACK status.
- Sits between the init trigger (power-up or user `go`) and the I2C master.

Parameters:
- CMD_COUNT, 41: number of ROM bytes sent, addresses 0..CMD_COUNT-1; legal range 1..128.
- DEV_ADDR, 7'h3C: 7-bit slave address; transmitted as {DEV_ADDR,1'b0} = 8'h78.
- CTRL_BYTE, 8'h00: SSD1306 control byte (Co=0, D/C#=0: command stream follows).
- RETRY_MAX, 3: retry limit; used only with OLED_SEQ_RETRY_EN.

Ports:
- ck  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- go  in  1  start request; sampled only in IDLE
- rom_addr  out  7  address to the command ROM
- rom_data  in  8  ROM output, combinational from rom_addr
- tx_valid  out  1  byte offered to the I2C master
- tx_ready  in  1  master accepts the byte when tx_valid && tx_ready
- tx_data  out  8  byte to send
- tx_start  out  1  qualifies tx_data: generate START before this byte
- tx_stop  out  1  qualifies tx_data: generate STOP after this byte's ACK
- tx_done  in  1  one-cycle pulse: accepted byte finished, ACK bit sampled
- tx_nack  in  1  valid with tx_done: slave NACKed; master issues STOP itself
- busy  out  1  high from accepted go until DONE/ERR exits
- done  out  1  one-cycle pulse: full sequence ACKed
- err  out  1  one-cycle pulse: sequence aborted on NACK

Behaviour:
- Reset values: state IDLE, idx=0, rom_addr=0, tx_valid=0, tx_start=0, tx_stop=0, tx_data=0, busy=0, done=0, err=0.
- States: IDLE, ADDR, ADDR_W, CTRL, CTRL_W, CMD, CMD_W, FIN, FAIL.
- IDLE:
  - go=1 goes to ADDR next cycle and sets busy.
  - go while busy is ignored; it is not queued.
- ADDR:
  - Outputs: tx_valid=1, tx_data=8'h78, tx_start=1.
  - Holds all outputs stable until tx_ready.
  - On the handshake cycle goes to ADDR_W and drops tx_valid next cycle.
- *_W states:
  - Wait for tx_done.
  - tx_done && tx_nack goes to FAIL.
  - tx_done && !tx_nack advances.
- CTRL: tx_data=CTRL_BYTE, tx_start=0, tx_stop=0; after its wait state goes to CMD with idx=0.
- CMD:
  - Outputs: tx_data=rom_data where rom_addr=idx; tx_stop=1 iff idx==CMD_COUNT-1.
  - CMD_W on ACK: if idx==CMD_COUNT-1 go to FIN, else idx+1 and back to CMD.
- rom_addr:
  - Registered copy of idx.
  - Stable for at least one cycle before tx_valid rises in CMD, and throughout the handshake.
- At most one byte outstanding; tx_valid never asserts in a *_W state.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- FAIL: err=1 for one cycle, busy=0, return to IDLE. No STOP is sent by this block; the master owns the STOP after a NACK.
- Throughput: with tx_ready tied high and tx_done one cycle after accept, one byte per 3 cycles.
- idx is 7 bits and never wraps; CMD_COUNT=128 ends at idx=127.
- A tx_done arriving outside a *_W state is ignored.
- Reset mid-transaction:
  - Immediate return to reset values; tx_valid drops asynchronously.
  - The master is reset by the same signal.

Optional Feature:
- Macro: OLED_SEQ_RETRY_EN.
- Defined:
  - A NACK in any *_W state increments a 2-bit retry counter and restarts at ADDR; idx=0 and the ADDR byte carries tx_start=1.
  - err fires only when a NACK occurs with retry count == RETRY_MAX.
  - The counter clears on go acceptance.
- Undefined: the first NACK goes straight to FAIL; no counter logic exists.

Decomposition:
- Shared package oled_pkg holds:
  - state enum encoding
  - SSD1306_ADDR=7'h3C
  - CTRL_CMD_STREAM=8'h00
  - CTRL_DATA_STREAM=8'h40
- No sub-module: a single FSM with the idx counter; the ROM is instantiated by the parent.

Test Plan:
- Full sequence: CMD_COUNT=41, tx_ready=1, tx_done 1 cycle after accept, never NACK -> accepted bytes exactly 78,00,AE,20,01,...,00. tx_start only on 78, tx_stop only on the 41st command byte, done pulses once, busy low after.
- NACK on the address byte -> no further tx_valid, err pulses once, done stays 0, state IDLE. With OLED_SEQ_RETRY_EN and one NACK -> 78 is resent, then the full sequence completes with done=1.
- Backpressure: tx_ready low for 5 cycles during CMD idx=10 -> tx_data=rom[10], rom_addr=10 and tx_valid held constant, no byte skipped or duplicated.
- go pulsed during busy at idx=20 -> ignored; sequence completes normally with exactly 43 bytes.
- Reset asserted asynchronously in CMD_W idx=5 -> all outputs at reset values before the next edge. A following go restarts from 78 with idx=0.
- CMD_COUNT=1 -> bytes 78,00,AE with tx_stop on AE; done pulses.
